muldiv_ctrl: RTL
================

# muldiv_ctrl

Execute-stage multiply/divide sequencer that owns the HI/LO write path. It accepts mult/multu/div/divu operands from the execute stage and runs a registered multiply or a 32-iteration restoring divide. It holds the pipeline with a stall while it works, then issues a one-cycle HI/LO write with the 64-bit result. It sits beside the ALU. Its stall output is ORed into the hazard unit's execute-stage stall, and its write pulse drives the HI/LO register file.

## Interface
Parameters:
- none; the datapath width is fixed at 32 bits.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- startE  in  1  a valid mult/multu/div/divu is in the execute stage
- opE  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu
- srcaE  in  32  rs operand (multiplicand / dividend), after forwarding
- srcbE  in  32  rt operand (multiplier / divisor), after forwarding
- cancel  in  1  annul any in-flight operation (exception/flush)
- stallE  out  1  hold the execute stage and everything upstream
- busy  out  1  FSM not in IDLE
- hi_o  out  32  HI result (high product word / remainder)
- lo_o  out  32  LO result (low product word / quotient)
- hilowrite_o  out  1  one-cycle write strobe for HI/LO

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE
  - startE=1 and cancel=0: latch opE, srcaE and srcbE.
  - Go to MUL (op 0x), or DIV (op 1x, divisor≠0), or DONE (op 1x, divisor=0).
- MUL
  - Form the 64-bit product of the latched operands: signed for op 00, unsigned for op 01.
  - Register it into {hi_o, lo_o}; go to DONE.
- DIV
  - Signed case: operate on absolute values.
  - Restoring divide, one quotient bit per cycle, MSB first.
  - Iteration counter runs 0..31. After count 31, apply sign fixup and load hi_o/lo_o; go to DONE.
  - Quotient negated iff operand signs differ (signed only).
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed) → lo=0x80000000, hi=0; two's-complement wrap, no trap.
- Divide by zero
  - hi_o = dividend, lo_o = 0xFFFFFFFF, for both signed and unsigned.
- DONE
  - hilowrite_o=1, stallE=0; always go to IDLE.
  - startE in DONE belongs to the instruction being released and is ignored.
- cancel (checked first, in any state)
  - Next state IDLE; hilowrite_o forced 0 that cycle; hi_o/lo_o keep their previous values.
  - Iteration counter and internal remainder/quotient registers are cleared.
- hi_o/lo_o hold the last completed result until the next completion.
- Arithmetic
  - Partial remainder register is 33 bits, to hold the trial-subtract borrow.
  - Product is 64 bits; no truncation.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, counter=0.
- Reset values: hi_o=0, lo_o=0, hilowrite_o=0, stallE=0, busy=0.
- Reset mid-operation aborts immediately with no write.
- stallE is combinational: (state==IDLE & startE & ~cancel) | state==MUL | state==DIV.
  - The instruction is held in E from its first cycle.
- Let S be the cycle startE is seen in IDLE.
  - mult/multu: stallE high in S and S+1; DONE at S+2 (hilowrite_o=1); IDLE at S+3.
  - div/divu, divisor≠0: stallE high in S..S+32; DONE at S+33.
  - div/divu, divisor=0: stallE high in S only; DONE at S+1.
- Back-to-back: a new startE is accepted in the IDLE cycle immediately after DONE. The minimum gap between hilowrite pulses is 3 cycles for mult.
- Outputs hi_o/lo_o update on the edge entering DONE; they are valid during the DONE cycle.
- cancel and startE together in IDLE: not accepted, stallE=0.
- Operand changes on srcaE/srcbE after S have no effect.

## Test plan
- multu 0xFFFFFFFF×0xFFFFFFFF at S → stallE high at S and S+1; at S+2 hilowrite_o=1, hi=0xFFFFFFFE, lo=0x00000001; busy=0 at S+3.
- mult −3×5 (0xFFFFFFFD, 0x00000005) → hi=0xFFFFFFFF, lo=0xFFFFFFF1 at S+2. Immediately follow with multu 2×3 → second pulse 3 cycles later, hi=0, lo=6.
- div sign and overflow cases, each with stallE high for exactly 33 cycles and a pulse at S+33:
  - −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
  - divu 0xFFFFFFFF/0x10 → lo=0x0FFFFFFF, hi=0xF.
- divu 100/0 → stallE high only at S; at S+1 hilowrite_o=1, hi=100, lo=0xFFFFFFFF.
- div 1000/7 with cancel at S+10:
  - S+11 is IDLE with no hilowrite pulse; hi/lo unchanged from the previous result.
  - divu 9/4 started at S+11 completes with lo=2, hi=1.
- rst low at S+5 of a divide → all outputs 0 without waiting for a clock edge. After release, divu 9/4 completes normally.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: execute-stage mult/div sequencer owning the HI/LO write.
// Single-cycle registered multiply, 32-step restoring divide.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        startE,
  input  logic [1:0]  opE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  input  logic        cancel,
  output logic        stallE,
  output logic        busy,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        hilowrite_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  r_state;
  logic        r_sgn;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_dvs;
  logic [31:0] r_quo;
  logic [32:0] r_rem;
  logic [4:0]  r_cnt;
  logic        r_negq;
  logic        r_negr;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_sa;
  logic        w_sb;
  logic [31:0] w_absa;
  logic [31:0] w_absb;
  logic [63:0] w_prod;
  logic [33:0] w_shift;
  logic [33:0] w_trial;
  logic        w_borrow;
  logic [32:0] w_rest;
  logic [31:0] w_quo_n;

  assign w_sa   = ~opE[0] & srcaE[31];
  assign w_sb   = ~opE[0] & srcbE[31];
  assign w_absa = w_sa ? (32'd0 - srcaE) : srcaE;
  assign w_absb = w_sb ? (32'd0 - srcbE) : srcbE;

  assign w_prod = {{32{r_sgn & r_a[31]}}, r_a}
                * {{32{r_sgn & r_b[31]}}, r_b};

  // dividend bits shift out of r_quo as quotient bits shift in
  assign w_shift  = {r_rem, r_quo[31]};
  assign w_trial  = w_shift - {2'b00, r_dvs};
  assign w_borrow = w_trial[33];
  assign w_rest   = w_borrow ? w_shift[32:0] : w_trial[32:0];
  assign w_quo_n  = {r_quo[30:0], ~w_borrow};

  assign stallE = ((r_state == IDLE) & startE & ~cancel)
                | (r_state == MUL) | (r_state == DIV);
  assign busy        = (r_state != IDLE);
  assign hilowrite_o = (r_state == DONE) & ~cancel;
  assign hi_o        = r_hi;
  assign lo_o        = r_lo;

  // sequencer state, operand latch, divide datapath and result regs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_sgn   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_dvs   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_negq  <= 1'b0;
      r_negr  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (cancel) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (startE) begin
            r_sgn  <= ~opE[0];
            r_a    <= srcaE;
            r_b    <= srcbE;
            r_quo  <= w_absa;
            r_dvs  <= w_absb;
            r_negq <= w_sa ^ w_sb;
            r_negr <= w_sa;
            r_rem  <= '0;
            r_cnt  <= '0;
            if (!opE[1]) begin
              r_state <= MUL;
            end else if (srcbE == 32'd0) begin
              r_hi    <= srcaE;
              r_lo    <= 32'hFFFF_FFFF;
              r_state <= DONE;
            end else begin
              r_state <= DIV;
            end
          end
        end
        MUL: begin
          r_hi    <= w_prod[63:32];
          r_lo    <= w_prod[31:0];
          r_state <= DONE;
        end
        DIV: begin
          r_rem <= w_rest;
          r_quo <= w_quo_n;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_lo    <= r_negq ? (32'd0 - w_quo_n) : w_quo_n;
            r_hi    <= r_negr ? (32'd0 - w_rest[31:0])
                              : w_rest[31:0];
            r_state <= DONE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
